e_mdu_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer for the E stage of the five-stage pipeline, placed beside the single-cycle ALU. It accepts mult/multu/div/divu, mthi/mtlo and mfhi/mflo operations. It owns the HI/LO registers and a latency counter that emulates the fixed unit latency. It also raises the D-stage stall request that keeps dependent multiply/divide instructions out of E while an operation is in flight.

---
 rtl/e_mdu_sequencer.sv | 149 ++++++++++++++
 tb/tb_e_mdu_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/e_mdu_sequencer.sv
// rtl/e_mdu_sequencer.sv - E-stage multi-cycle multiply/divide sequencer owning HI/LO
module e_mdu_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] md_rdata,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [1:0] K_MULT  = 2'd0;
  localparam logic [1:0] K_MULTU = 2'd1;
  localparam logic [1:0] K_DIV   = 2'd2;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  kind_q, kind_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] hi_d, lo_d;
  logic        start_now;

  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b, num, den, uq, ur;
  logic [31:0] res_hi, res_lo;
  logic        commit_en;

  assign busy      = (state_q == S_RUN);
  assign start_now = (md_op >= OP_MULT) && (md_op <= OP_DIVU) && !busy;
  assign stall_req = d_md_use & (busy | start_now);

  always_comb begin
    case (md_op)
      OP_MFHI: md_rdata = hi_q;
      OP_MFLO: md_rdata = lo_q;
      default: md_rdata = 32'd0;
    endcase
  end

  // One unsigned divider serves both div flavours; signed div works on magnitudes
  // and re-applies signs, which also yields 0x80000000/-1 = 0x80000000 rem 0.
  always_comb begin
    prod_s = $signed({{32{op_a_q[31]}}, op_a_q}) * $signed({{32{op_b_q[31]}}, op_b_q});
    prod_u = {32'd0, op_a_q} * {32'd0, op_b_q};
    mag_a  = op_a_q[31] ? -op_a_q : op_a_q;
    mag_b  = op_b_q[31] ? -op_b_q : op_b_q;
    num    = (kind_q == K_DIV) ? mag_a : op_a_q;
    den    = (kind_q == K_DIV) ? mag_b : op_b_q;
    if (den == 32'd0) den = 32'd1;
    uq     = num / den;
    ur     = num % den;
    commit_en = 1'b1;
    case (kind_q)
      K_MULT:  {res_hi, res_lo} = prod_s;
      K_MULTU: {res_hi, res_lo} = prod_u;
      K_DIV: begin
        res_lo = (op_a_q[31] ^ op_b_q[31]) ? -uq : uq;
        res_hi = op_a_q[31] ? -ur : ur;
        commit_en = (op_b_q != 32'd0);
      end
      default: begin
        res_lo = uq;
        res_hi = ur;
        commit_en = (op_b_q != 32'd0);
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start_now) begin
          state_d = S_RUN;
          op_a_d  = src_a;
          op_b_d  = src_b;
          kind_d  = 2'(md_op - 4'd1);
          cnt_d   = (md_op <= OP_MULTU) ? MULT_N : DIV_N;
        end else if (md_op == OP_MTHI) begin
          hi_d = src_a;
        end else if (md_op == OP_MTLO) begin
          lo_d = src_a;
        end
      end
      default: begin
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
          if (commit_en) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      kind_q  <= 2'd0;
      op_a_q  <= 32'd0;
      op_b_q  <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_e_mdu_sequencer.sv
// tb/tb_e_mdu_sequencer.sv - scoreboard bench for the E-stage multiply/divide sequencer
module tb_e_mdu_sequencer;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        d_md_use = 1'b0;
  logic        busy, stall_req;
  logic [31:0] md_rdata, hi_q, lo_q;

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  e_mdu_sequencer dut (
    .clk(clk), .reset(reset), .md_op(md_op), .src_a(src_a), .src_b(src_b),
    .d_md_use(d_md_use), .busy(busy), .stall_req(stall_req),
    .md_rdata(md_rdata), .hi_q(hi_q), .lo_q(lo_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input res_t old);
    res_t r;
    longint sa, sb_, sq, sr;
    longint unsigned up;
    r = old;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    case (op)
      4'd1: begin sq = sa * sb_; {r.hi, r.lo} = sq[63:0]; end
      4'd2: begin up = longint'({32'd0, a}) * longint'({32'd0, b}); {r.hi, r.lo} = up; end
      4'd3: if (b != 0) begin sq = sa / sb_; sr = sa % sb_; r.lo = sq[31:0]; r.hi = sr[31:0]; end
      default: if (b != 0) begin r.lo = a / b; r.hi = a % b; end
    endcase
    return r;
  endfunction

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    @(negedge clk);
    md_op = op; src_a = v;
    @(negedge clk);
    md_op = 4'd0;
    if (op == 4'd7) m_hi = v; else m_lo = v;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int n, nb;
    res_t e;
    n  = (op <= 4'd2) ? 5 : 10;
    nb = 0;
    @(negedge clk);
    md_op = op; src_a = a; src_b = b;
    sb.push_back('{hi: ehi, lo: elo});
    @(negedge clk);
    md_op = 4'd0; src_a = $urandom; src_b = $urandom;
    while (busy === 1'b1 && nb < 40) begin
      nb++;
      if (nb == n) begin
        chk("hold_hi", hi_q, m_hi);
        chk("hold_lo", lo_q, m_lo);
      end
      @(negedge clk);
    end
    chk("busy_cycles", 32'(nb), 32'(n));
    md_op = 4'd5; #1;
    chk("mfhi_read", md_rdata, ehi);
    md_op = 4'd6; #1;
    chk("mflo_read", md_rdata, elo);
    md_op = 4'd0;
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("hi_q", hi_q, e.hi);
      chk("lo_q", lo_q, e.lo);
    end
    m_hi = ehi; m_lo = elo;
  endtask

  initial begin
    res_t cur, ex;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int nb;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi_q, 32'd0);
    chk("rst_lo", lo_q, 32'd0);
    chk("rst_rdata", md_rdata, 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    reset = 1'b1;

    run_op(4'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op(4'd2, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    mt(4'd7, 32'h11);
    mt(4'd8, 32'h22);
    run_op(4'd4, 32'd7, 32'd0, 32'h11, 32'h22);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

    mt(4'd7, 32'hDEADBEEF);
    md_op = 4'd5; #1;
    chk("mthi_then_mfhi", md_rdata, 32'hDEADBEEF);
    md_op = 4'd0;

    for (int i = 0; i < 6; i++) begin
      rop = 4'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 28);
      if (rb == 32'd0) rb = 32'd1;
      if (i == 5) ra = 32'h80000000;
      cur = '{hi: m_hi, lo: m_lo};
      ex  = model(rop, ra, rb, cur);
      run_op(rop, ra, rb, ex.hi, ex.lo);
    end

    // Hazard: stall through start and busy; ops arriving while busy are ignored.
    @(negedge clk);
    d_md_use = 1'b1;
    md_op = 4'd1; src_a = 32'd3; src_b = 32'd5;
    #1;
    chk("stall_start", 32'(stall_req), 32'd1);
    nb = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      case (k)
        1: md_op = 4'd6;
        2: begin md_op = 4'd1; src_a = 32'd7; src_b = 32'd7; end
        3: begin md_op = 4'd7; src_a = 32'h55; end
        default: md_op = 4'd0;
      endcase
      #1;
      if (busy !== 1'b1) break;
      nb++;
      chk("stall_busy", 32'(stall_req), 32'd1);
    end
    chk("hazard_busy_cycles", 32'(nb), 32'd5);
    chk("stall_after", 32'(stall_req), 32'd0);
    chk("hazard_hi", hi_q, 32'd0);
    chk("hazard_lo", lo_q, 32'd15);
    d_md_use = 1'b0;
    md_op = 4'd0;

    // Reset in busy cycle 3 of a mult discards the result.
    @(negedge clk);
    md_op = 4'd1; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    md_op = 4'd0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_hi", hi_q, 32'd0);
    chk("midrst_lo", lo_q, 32'd0);
    repeat (8) @(negedge clk);
    chk("midrst_late_hi", hi_q, 32'd0);
    chk("midrst_late_lo", lo_q, 32'd0);
    chk("midrst_late_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
